// File: rtl/bus_fabric_pkg.sv
// Shared constants for the bus fabric: contention counter sizing and hold modes.
package bus_fabric_pkg;
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Idle-bus behaviour selectors for HOLD_MODE
    localparam int HOLD_ZERO = 0;
    localparam int HOLD_LAST = 1;
endpackage

// File: rtl/bus_fabric_prio_onehot.sv
// Lowest-set-bit one-hot encoder with an "any request" flag.
module prio_onehot #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         any
);
    // Two's-complement trick isolates the lowest set bit; zero input gives zero.
    assign onehot = req & (~req + N'(1));
    assign any    = |req;
endmodule

// File: rtl/bus_fabric.sv
// Shared-bus fabric: fixed-priority bus drive, optional idle hold,
// sticky contention diagnostics and a rate-divided LED snapshot.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_SRC     = 6,
    parameter int LED_W     = 5,
    parameter int LED_DIV   = 1,
    parameter int HOLD_MODE = HOLD_ZERO
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_en,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       bus,
    output logic                   bus_valid,
    output logic [N_SRC-1:0]       grant,
    output logic                   contention,
    output logic                   err_sticky,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic [N_SRC-1:0]       err_src,
    output logic [LED_W-1:0]       led
);
    localparam int DIV_W = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LED_DIV - 1);

    logic [WIDTH-1:0] bus_sel;
    logic [WIDTH-1:0] hold_q;
    logic [DIV_W-1:0] div_q;

    prio_onehot #(.N(N_SRC)) u_prio (
        .req    (src_en),
        .onehot (grant),
        .any    (bus_valid)
    );

    // More than one enable set; always zero for a single source.
    assign contention = (src_en & (src_en - N_SRC'(1))) != '0;

    // AND-OR mux of source words under the one-hot grant, then idle policy.
    always_comb begin
        bus_sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) bus_sel = bus_sel | src_data[i*WIDTH +: WIDTH];
        end
        bus = bus_valid ? bus_sel : ((HOLD_MODE == HOLD_LAST) ? hold_q : '0);
    end

    // Remember the last actively driven value for hold mode.
    always_ff @(posedge clk) begin
        if (rst)            hold_q <= '0;
        else if (bus_valid) hold_q <= bus_sel;
    end

    // Contention log: clear first, then record; first offender kept until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
            err_src    <= '0;
        end else if (contention) begin
            err_sticky <= 1'b1;
            if (clr_err) begin
                err_count <= ERR_CNT_W'(1);
                err_src   <= src_en;
            end else begin
                if (err_count != ERR_CNT_MAX) err_count <= err_count + ERR_CNT_W'(1);
                if (!err_sticky)              err_src   <= src_en;
            end
        end else if (clr_err) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
            err_src    <= '0;
        end
    end

    // LED refresh divider: snapshot bus low bits on the last count of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            led   <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            led   <= bus[LED_W-1:0];
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end
endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench: table of arbitration vectors plus hand sequences for
// error logging, hold, saturation, LED divider and mid-operation reset.
module tb_bus_fabric;
    localparam int W = 16;
    localparam int N = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] src_data;
    logic [N-1:0]  src_en;
    logic          clr_err;

    // dut0: HOLD_MODE=0, LED_DIV=4 ; dut1: HOLD_MODE=1, LED_DIV=1
    logic [W-1:0] bus0, bus1;
    logic         valid0, valid1, cont0, cont1, sticky0, sticky1;
    logic [N-1:0] grant0, grant1, esrc0, esrc1;
    logic [7:0]   ecnt0, ecnt1;
    logic [4:0]   led0, led1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_fabric #(.WIDTH(W), .N_SRC(N), .LED_W(5), .LED_DIV(4), .HOLD_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .src_data(src_data), .src_en(src_en), .clr_err(clr_err),
        .bus(bus0), .bus_valid(valid0), .grant(grant0), .contention(cont0),
        .err_sticky(sticky0), .err_count(ecnt0), .err_src(esrc0), .led(led0)
    );

    bus_fabric #(.WIDTH(W), .N_SRC(N), .LED_W(5), .LED_DIV(1), .HOLD_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .src_data(src_data), .src_en(src_en), .clr_err(clr_err),
        .bus(bus1), .bus_valid(valid1), .grant(grant1), .contention(cont1),
        .err_sticky(sticky1), .err_count(ecnt1), .err_src(esrc1), .led(led1)
    );

    typedef struct {
        logic [N-1:0] en;
        logic [W-1:0] bus0;
        logic [W-1:0] bus1;
        logic [N-1:0] grant;
        logic         valid;
        logic         cont;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setw(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; src_en = '0; clr_err = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_err(input string tag, input logic st, input logic [7:0] cnt, input logic [N-1:0] es);
        chk({tag, ".sticky0"}, 32'(sticky0), 32'(st));
        chk({tag, ".count0"},  32'(ecnt0),   32'(cnt));
        chk({tag, ".src0"},    32'(esrc0),   32'(es));
        chk({tag, ".count1"},  32'(ecnt1),   32'(cnt));
    endtask

    initial begin
        src_data = '0;
        rst = 1'b1; src_en = '0; clr_err = 1'b0;
        // en, bus(hold 0), bus(hold 1), grant, valid, contention
        vecs[0] = '{6'b000100, 16'h1234, 16'h1234, 6'b000100, 1'b1, 1'b0};
        vecs[1] = '{6'b010010, 16'hAAAA, 16'hAAAA, 6'b000010, 1'b1, 1'b1};
        vecs[2] = '{6'b000000, 16'h0000, 16'hAAAA, 6'b000000, 1'b0, 1'b0};
        vecs[3] = '{6'b100000, 16'hCAFE, 16'hCAFE, 6'b100000, 1'b1, 1'b0};
        vecs[4] = '{6'b111111, 16'h0F0F, 16'h0F0F, 6'b000001, 1'b1, 1'b1};
        vecs[5] = '{6'b101000, 16'h3333, 16'h3333, 6'b001000, 1'b1, 1'b1};
        vecs[6] = '{6'b011000, 16'h3333, 16'h3333, 6'b001000, 1'b1, 1'b1};
        vecs[7] = '{6'b010000, 16'h5555, 16'h5555, 6'b010000, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk_err("reset", 1'b0, 8'd0, 6'b0);
        chk("reset.led0", 32'(led0), 32'd0);
        chk("reset.led1", 32'(led1), 32'd0);
        chk("reset.bus1_idle", 32'(bus1), 32'd0);

        // Table: arbitration, priority, contention flag, idle/hold
        setw(0, 16'h0F0F); setw(1, 16'hAAAA); setw(2, 16'h1234);
        setw(3, 16'h3333); setw(4, 16'h5555); setw(5, 16'hCAFE);
        for (int r = 0; r < 8; r++) begin
            src_en = vecs[r].en;
            #1;
            chk($sformatf("vec%0d.bus0", r),  32'(bus0),   32'(vecs[r].bus0));
            chk($sformatf("vec%0d.bus1", r),  32'(bus1),   32'(vecs[r].bus1));
            chk($sformatf("vec%0d.grant", r), 32'(grant0), 32'(vecs[r].grant));
            chk($sformatf("vec%0d.valid", r), 32'(valid0), 32'(vecs[r].valid));
            chk($sformatf("vec%0d.cont", r),  32'(cont0),  32'(vecs[r].cont));
            tick();
        end

        // Single source leaves diagnostics clear
        do_reset();
        src_en = 6'b000100;
        tick();
        chk_err("single", 1'b0, 8'd0, 6'b0);

        // Contention logging, first offender retained
        do_reset();
        src_en = 6'b010010;
        tick();
        chk_err("cont1", 1'b1, 8'd1, 6'b010010);
        src_en = 6'b000011;
        #1;
        chk("cont2.bus", 32'(bus0), 32'h0F0F);
        tick();
        chk_err("cont2", 1'b1, 8'd2, 6'b010010);

        // Idle and hold, then reset while idle
        do_reset();
        setw(0, 16'hBEEF);
        src_en = 6'b000001;
        tick();
        src_en = '0;
        #1;
        chk("hold.bus0", 32'(bus0), 32'h0000);
        chk("hold.bus1", 32'(bus1), 32'hBEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hold.rst_bus1", 32'(bus1), 32'h0000);

        // Saturation and clear
        do_reset();
        src_en = 6'b000011;
        for (int i = 0; i < 300; i++) tick();
        chk_err("sat", 1'b1, 8'd255, 6'b000011);
        src_en = '0; clr_err = 1'b1;
        tick();
        chk_err("clr", 1'b0, 8'd0, 6'b0);
        src_en = 6'b100001;
        tick();
        chk_err("clr_cont", 1'b1, 8'd1, 6'b100001);
        clr_err = 1'b0;
        src_en = 6'b100000;
        tick();
        chk_err("clr_after", 1'b1, 8'd1, 6'b100001);

        // LED divider: bus steps 0,1,2,... from reset
        rst = 1'b1; src_en = 6'b000001; setw(0, 16'h0000);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            logic [4:0] e0;
            setw(0, 16'(n));
            tick();
            e0 = (n < 3) ? 5'd0 : 5'(n - ((n - 3) % 4));
            chk($sformatf("led_div4.c%0d", n), 32'(led0), 32'(e0));
            chk($sformatf("led_div1.c%0d", n), 32'(led1), 32'(n));
        end

        // Mid-operation reset during a contention burst
        do_reset();
        setw(0, 16'h0013);
        src_en = 6'b000011;
        for (int i = 0; i < 10; i++) tick();
        chk_err("mid.pre", 1'b1, 8'd10, 6'b000011);
        chk("mid.pre_led1", 32'(led1), 32'h13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_err("mid.post", 1'b0, 8'd0, 6'b0);
        chk("mid.led0", 32'(led0), 32'd0);
        chk("mid.led1", 32'(led1), 32'd0);
        src_en = 6'b000001; setw(0, 16'h0009);
        tick(); tick(); tick();
        chk("mid.div_hold", 32'(led0), 32'd0);
        tick();
        chk("mid.div_first", 32'(led0), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
Parametrised shared-bus fabric for the CPU datapath. Takes N_SRC source data words and their output enables, drives one WIDTH-bit bus by fixed priority (lowest index wins), and optionally holds the last driven value while the bus is idle. Detects and logs contention (more than one enable in a cycle) with sticky diagnostics. Drives a rate-divided LED snapshot of the bus low bits for the board.

Parameters:
WIDTH, 16, bus data width
N_SRC, 6, number of bus sources; index 0 = highest priority
LED_W, 5, LED snapshot width; LED_W <= WIDTH
LED_DIV, 1, LED refresh period in cycles; >= 1
HOLD_MODE, 0, 0: idle bus reads 0; 1: idle bus reads last driven value

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
src_data  in  N_SRC*WIDTH  source words; source i at [i*WIDTH +: WIDTH]
src_en  in  N_SRC  per-source output enable
clr_err  in  1  clears contention diagnostics
bus  out  WIDTH  shared bus value (combinational)
bus_valid  out  1  some src_en bit set this cycle (combinational)
grant  out  N_SRC  one-hot winning source, 0 if idle (combinational)
contention  out  1  popcount(src_en) > 1 this cycle (combinational)
err_sticky  out  1  contention seen since reset/clear (registered)
err_count  out  8  saturating contention-cycle count (registered)
err_src  out  N_SRC  src_en captured at first contention (registered)
led  out  LED_W  bus[LED_W-1:0] snapshot (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values: hold_q=0, err_sticky=0, err_count=0, err_src=0, led=0, divider count=0.
- Arbitration, combinational:
  - grant is the lowest set bit of src_en.
  - bus = src_data of the granted source.
  - When idle: bus = 0 if HOLD_MODE=0, else bus = hold_q.
  - Zero latency from src_en/src_data to bus.
- hold_q: loads bus every cycle bus_valid=1; otherwise keeps its value. With HOLD_MODE=0 it is unused and may be optimised away.
- Contention (a cycle with contention=1):
  - err_count increments, saturating at 255 (stays at 255).
  - err_sticky is set.
  - err_src loads src_en only if err_sticky was 0, so the first offender is retained.
  - The bus still resolves by priority.
- clr_err:
  - Zeroes err_sticky, err_count and err_src.
  - If contention occurs in the same cycle: treated as clear-then-record, giving err_sticky=1, err_count=1, err_src=src_en.
- rst overrides clr_err and contention.
- LED divider:
  - Counter runs 0..LED_DIV-1 and wraps.
  - On the cycle the counter equals LED_DIV-1, led <= bus[LED_W-1:0].
  - LED_DIV=1 means led updates every cycle with one cycle of latency.
  - First update after reset occurs at cycle LED_DIV-1.
- Reset mid-operation: all registered outputs return to reset values next edge. Combinational bus reflects inputs immediately; in HOLD_MODE=1 an idle bus reads 0 after reset.
- Width rules: N_SRC >= 1. With N_SRC=1, contention is constantly 0. Divider width is clog2(LED_DIV), minimum 1.

Decomposition:
- Shared package: localparam ERR_CNT_W=8, ERR_CNT_MAX=255, and the mode constants HOLD_ZERO=0 and HOLD_LAST=1.
- One natural sub-module, prio_onehot: N-bit lowest-set-bit one-hot encoder plus an "any" output, reusable by the controller.
- Contention detection (popcount > 1) is computed inline as (src_en & (src_en-1)) != 0.

Test Plan:
1. Single source: src_en=6'b000100, src_data[2]=16'h1234 -> bus=16'h1234, grant=6'b000100, bus_valid=1, contention=0; err_* remain 0.
2. Priority and contention: src_en=6'b010010 with src1=16'hAAAA, src4=16'h5555 -> bus=16'hAAAA, contention=1. Next cycle: err_sticky=1, err_count=1, err_src=6'b010010. A second contention with src_en=6'b000011 leaves err_src=6'b010010 and gives err_count=2.
3. Idle and hold: with HOLD_MODE=0, drive 16'hBEEF then src_en=0 -> bus=0. With HOLD_MODE=1, same sequence -> bus=16'hBEEF while idle. Assert rst while idle -> bus=0.
4. Saturation and clear: 300 consecutive contention cycles -> err_count=255. Then clr_err with no contention -> all err_* = 0. Then clr_err together with contention src_en=6'b100001 -> err_count=1, err_sticky=1, err_src=6'b100001.
5. LED divider: LED_DIV=4, bus stepping 0,1,2,3,... each cycle from reset -> led updates only at cycles 3, 7, 11 to 5'd3, 5'd7, 5'd11. With LED_DIV=1, led equals bus[4:0] delayed one cycle.
6. Mid-operation reset: rst=1 during a contention burst with err_count=10 and led non-zero -> next edge err_count=0, err_sticky=0, err_src=0, led=0, divider restarts at 0.
